// File: rtl/assoc_cache.sv
// assoc_cache: set-associative tag/data store with one-cycle lookup,
// round-robin victim selection and a one-set-per-cycle invalidate sweep.
module assoc_cache #(
  parameter int WAYS    = 2,
  parameter int INDEX_W = 8,
  parameter int WORD_W  = 2,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 16,
  localparam int WW     = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [INDEX_W-1:0] index,
  input  logic [WORD_W-1:0] word,
  input  logic              comp,
  input  logic              write,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              flush,
  output logic              ready,
  output logic              resp_valid,
  output logic              hit,
  output logic              dirty,
  output logic              valid,
  output logic [TAG_W-1:0]  tag_out,
  output logic [DATA_W-1:0] data_out,
  output logic [WW-1:0]     way_out,
  output logic              flush_busy
);
  localparam int SETS  = 1 << INDEX_W;
  localparam int WORDS = 1 << WORD_W;

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t             state_q;
  state_t             state_n;
  logic [INDEX_W-1:0] cnt_q;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS][WORDS];
  logic [WW-1:0]     vptr_q  [SETS];

  logic          acc;
  logic          hit_c;
  logic          found;
  logic          wr_hit;
  logic          wr_vic;
  logic [WW-1:0] hit_way;
  logic [WW-1:0] vic_way;
  logic [WW-1:0] sel;
  logic [WW-1:0] vptr_nx;

  assign flush_busy = (state_q == S_SWEEP);
  assign ready      = !flush_busy && !flush;
  assign acc        = enable && ready && !rst;
  assign wr_hit     = acc && comp && write && hit_c;
  assign wr_vic     = acc && !comp && write;

  // Tag match, victim choice and the way that answers this request
  always_comb begin
    hit_c   = 1'b0;
    hit_way = '0;
    found   = 1'b0;
    vic_way = vptr_q[index];
    for (int w = 0; w < WAYS; w++) begin
      if (!hit_c && valid_q[index][w] &&
          tag_q[index][w] == tag_in) begin
        hit_c   = 1'b1;
        hit_way = w[WW-1:0];
      end
      if (!found && !valid_q[index][w]) begin
        found   = 1'b1;
        vic_way = w[WW-1:0];
      end
    end
    sel = (comp && hit_c) ? hit_way : vic_way;
    vptr_nx = (vptr_q[index] == WW'(WAYS - 1)) ?
              '0 : vptr_q[index] + 1'b1;
  end

  // Sweep state: idle until a flush pulse, then walk every set once
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      S_IDLE:  if (flush) state_n = S_SWEEP;
      S_SWEEP: if (&cnt_q) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Sweep state register; reset restarts the sweep from set 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= flush_busy ? cnt_q + 1'b1 : '0;
    end
  end

  // Line storage: sweep clears status, requests update one line
  always_ff @(posedge clk) begin
    if (flush_busy) begin
      valid_q[cnt_q] <= '0;
      dirty_q[cnt_q] <= '0;
      vptr_q[cnt_q]  <= '0;
    end else begin
      if (wr_hit) begin
        data_q[index][sel][word] <= data_in;
        dirty_q[index][sel]      <= 1'b1;
      end
      if (wr_vic) begin
        tag_q[index][sel]        <= tag_in;
        valid_q[index][sel]      <= valid_in;
        dirty_q[index][sel]      <= 1'b0;
        data_q[index][sel][word] <= data_in;
        vptr_q[index]            <= vptr_nx;
      end
    end
  end

  // Response register: reports the selected line after its update
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      hit        <= 1'b0;
      dirty      <= 1'b0;
      valid      <= 1'b0;
      tag_out    <= '0;
      data_out   <= '0;
      way_out    <= '0;
    end else begin
      resp_valid <= acc;
      if (acc) begin
        hit      <= comp && hit_c;
        way_out  <= sel;
        tag_out  <= wr_vic ? tag_in : tag_q[index][sel];
        valid    <= wr_vic ? valid_in : valid_q[index][sel];
        dirty    <= wr_hit ? 1'b1 :
                    (wr_vic ? 1'b0 : dirty_q[index][sel]);
        data_out <= (wr_hit || wr_vic) ?
                    data_in : data_q[index][sel][word];
      end
    end
  end

endmodule

// File: tb/tb_assoc_cache.sv
// tb_assoc_cache: random + directed stimulus against a line-level
// model of the cache; a per-cycle compare process checks every output.
module tb_assoc_cache;
  localparam int WAYS    = 2;
  localparam int INDEX_W = 8;
  localparam int WORD_W  = 2;
  localparam int TAG_W   = 5;
  localparam int DATA_W  = 16;
  localparam int SETS    = 256;
  localparam int WORDS   = 4;
  localparam int WW      = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic [INDEX_W-1:0] index = '0;
  logic [WORD_W-1:0] word = '0;
  logic              comp = 1'b0;
  logic              write = 1'b0;
  logic [TAG_W-1:0]  tag_in = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic              valid_in = 1'b0;
  logic              flush = 1'b0;
  logic              ready;
  logic              resp_valid;
  logic              hit;
  logic              dirty;
  logic              valid;
  logic [TAG_W-1:0]  tag_out;
  logic [DATA_W-1:0] data_out;
  logic [WW-1:0]     way_out;
  logic              flush_busy;

  always #5 clk = ~clk;

  assoc_cache #(
    .WAYS(WAYS), .INDEX_W(INDEX_W), .WORD_W(WORD_W),
    .TAG_W(TAG_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .index(index),
    .word(word), .comp(comp), .write(write), .tag_in(tag_in),
    .data_in(data_in), .valid_in(valid_in), .flush(flush),
    .ready(ready), .resp_valid(resp_valid), .hit(hit),
    .dirty(dirty), .valid(valid), .tag_out(tag_out),
    .data_out(data_out), .way_out(way_out),
    .flush_busy(flush_busy)
  );

  int tests = 0;
  int fails = 0;

  bit m_valid [SETS][WAYS];
  bit m_dirty [SETS][WAYS];
  int m_tag   [SETS][WAYS];
  int m_data  [SETS][WAYS][WORDS];
  bit k_tag   [SETS][WAYS];
  bit k_data  [SETS][WAYS][WORDS];
  int m_vptr  [SETS];
  int busy_left = 0;

  bit started = 0;
  bit p_rst, p_rv, p_hit, p_dirty, p_valid, p_busy;
  bit p_ktag, p_kdata;
  int p_tag, p_data, p_way;
  bit rdy_drv;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic int victim(input int s);
    for (int w = 0; w < WAYS; w++)
      if (!m_valid[s][w]) return w;
    return m_vptr[s];
  endfunction

  function automatic void clear_all();
    for (int s = 0; s < SETS; s++) begin
      m_vptr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
      end
    end
  endfunction

  // Per-cycle check of every output against the model's prediction
  always @(posedge clk) begin
    if (started) begin
      #2;
      chk("flush_busy", 32'(flush_busy), 32'(p_busy));
      chk("ready", 32'(ready), 32'(!p_busy && !flush));
      chk("resp_valid", 32'(resp_valid), 32'(p_rv));
      if (p_rst) begin
        chk("rst_outs", {hit, dirty, valid, tag_out, data_out,
                         way_out}, 32'd0);
      end
      if (p_rv) begin
        chk("hit", 32'(hit), 32'(p_hit));
        chk("valid", 32'(valid), 32'(p_valid));
        chk("dirty", 32'(dirty), 32'(p_dirty));
        chk("way_out", 32'(way_out), p_way);
        if (p_ktag) chk("tag_out", 32'(tag_out), p_tag);
        if (p_kdata) chk("data_out", 32'(data_out), p_data);
      end
    end
  end

  task automatic step(input bit r, input bit en, input bit cp,
                      input bit wr, input int idx, input int wd,
                      input int tg, input int dt, input bit vin,
                      input bit fl);
    bit acc;
    int hw, sel;
    @(negedge clk);
    rst = r; enable = en; comp = cp; write = wr;
    index = 8'(idx); word = 2'(wd); tag_in = 5'(tg);
    data_in = 16'(dt); valid_in = vin; flush = fl;
    started = 1;
    acc = !r && en && busy_left == 0 && !fl;
    p_rst = r;
    p_rv = acc;
    if (acc) begin
      hw = -1;
      for (int w = 0; w < WAYS; w++)
        if (hw < 0 && m_valid[idx][w] && m_tag[idx][w] == tg)
          hw = w;
      sel = (cp && hw >= 0) ? hw : victim(idx);
      if (cp && wr && hw >= 0) begin
        m_data[idx][sel][wd] = dt;
        k_data[idx][sel][wd] = 1;
        m_dirty[idx][sel] = 1;
      end
      if (!cp && wr) begin
        m_tag[idx][sel] = tg;
        k_tag[idx][sel] = 1;
        m_valid[idx][sel] = vin;
        m_dirty[idx][sel] = 0;
        m_data[idx][sel][wd] = dt;
        k_data[idx][sel][wd] = 1;
        m_vptr[idx] = (m_vptr[idx] + 1) % WAYS;
      end
      p_hit = cp && hw >= 0;
      p_way = sel;
      p_tag = m_tag[idx][sel];
      p_ktag = k_tag[idx][sel];
      p_data = m_data[idx][sel][wd];
      p_kdata = k_data[idx][sel][wd];
      p_valid = m_valid[idx][sel];
      p_dirty = m_dirty[idx][sel];
    end
    if (r) begin
      busy_left = SETS;
      clear_all();
    end else if (busy_left > 0) begin
      busy_left--;
    end else if (fl) begin
      busy_left = SETS;
      clear_all();
    end
    p_busy = busy_left > 0;
    #1 rdy_drv = ready;
    @(posedge clk);
    #3;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic sweep_wait(input int pulse_at, output int n);
    n = 0;
    while (flush_busy === 1'b1 && n < 400) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, n == pulse_at);
      n++;
    end
  endtask

  initial begin
    int n;
    int idxs [5] = '{0, 1, 2, 3, 255};
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        k_tag[s][w] = 0;
        m_tag[s][w] = 0;
        for (int d = 0; d < WORDS; d++) begin
          k_data[s][w][d] = 0;
          m_data[s][w][d] = 0;
        end
      end
    clear_all();

    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    sweep_wait(-1, n);
    chk("rst_sweep_len", n, 256);
    chk("ready_after_sweep", 32'(ready), 32'd1);

    step(0, 1, 0, 1, 3, 1, 'h0A, 'hBEEF, 1, 0);
    chk("aw_way", 32'(way_out), 32'd0);
    step(0, 1, 1, 0, 3, 1, 'h0A, 0, 0, 0);
    chk("m_rd1_hit", 32'(p_hit), 32'd1);
    chk("rd1_hit", 32'(hit), 32'd1);
    chk("rd1_data", 32'(data_out), 32'hBEEF);
    chk("rd1_dirty", 32'(dirty), 32'd0);
    chk("rd1_way", 32'(way_out), 32'd0);

    step(0, 1, 1, 1, 3, 1, 'h0A, 'h1234, 0, 0);
    step(0, 1, 1, 0, 3, 1, 'h0A, 0, 0, 0);
    chk("m_rd2_data", p_data, 32'h1234);
    chk("rd2_hit", 32'(hit), 32'd1);
    chk("rd2_dirty", 32'(dirty), 32'd1);
    chk("rd2_data", 32'(data_out), 32'h1234);

    step(0, 1, 0, 1, 3, 1, 'h0B, 'h5555, 1, 0);
    chk("aw2_way", 32'(way_out), 32'd1);
    step(0, 1, 1, 0, 3, 1, 'h0C, 0, 0, 0);
    chk("m_miss_tag", p_tag, 32'h0A);
    chk("miss_hit", 32'(hit), 32'd0);
    chk("miss_way", 32'(way_out), 32'd0);
    chk("miss_tag", 32'(tag_out), 32'h0A);
    chk("miss_dirty", 32'(dirty), 32'd1);

    step(0, 1, 1, 0, 3, 1, 'h0B, 0, 0, 0);
    step(0, 1, 1, 0, 3, 1, 'h0A, 0, 0, 1);
    chk("flush_ready", 32'(rdy_drv), 32'd0);
    chk("flush_no_resp", 32'(resp_valid), 32'd0);
    sweep_wait(100, n);
    chk("flush_sweep_len", n, 256);
    step(0, 1, 1, 0, 3, 1, 'h0A, 0, 0, 0);
    chk("post_hit", 32'(hit), 32'd0);
    chk("post_valid", 32'(valid), 32'd0);
    chk("post_tag", 32'(tag_out), 32'h0A);
    chk("post_data", 32'(data_out), 32'h1234);

    for (int i = 0; i < 6000; i++) begin
      bit r, en, cp, wr, vin, fl;
      int idx, tg, v;
      r = $urandom_range(0, 1999) == 0;
      fl = $urandom_range(0, 499) == 0;
      en = $urandom_range(0, 3) != 0;
      cp = $urandom_range(0, 1) == 1;
      wr = $urandom_range(0, 1) == 1;
      vin = $urandom_range(0, 3) != 0;
      idx = idxs[$urandom_range(0, 4)];
      tg = $urandom_range(0, 3);
      if (!cp && wr && vin) begin
        v = victim(idx);
        for (int w = 0; w < WAYS; w++)
          if (w != v && m_valid[idx][w] && m_tag[idx][w] == tg)
            vin = 0;
      end
      step(r, en, cp, wr, idx, $urandom_range(0, 3), tg,
           $urandom_range(0, 65535), vin, fl);
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
